// File: rtl/alu_operand_aligner_if.sv
// alu_operand_aligner_if: data/valid/ready stream with tlast/dest/user sideband.
interface alu_operand_aligner_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [3:0]            dest;
    logic                  user;
    modport master (output data, valid, last, dest, user, input ready);
    modport slave  (input data, valid, last, dest, user, output ready);
endinterface

// File: rtl/alu_operand_aligner.sv
// alu_operand_aligner: buffers A/B operands in per-side FIFOs and releases them as in-order aligned pairs.
// Define ALU_ALIGNER_SKEW_MON_EN to add the saturating max_skew monitor output.
module alu_operand_aligner #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    alu_operand_aligner_if.slave        in_a,
    alu_operand_aligner_if.slave        in_b,
    alu_operand_aligner_if.master       out_a,
    alu_operand_aligner_if.master       out_b,
    output logic [$clog2(DEPTH):0]      pending_a,
    output logic [$clog2(DEPTH):0]      pending_b
`ifdef ALU_ALIGNER_SKEW_MON_EN
    ,
    output logic [15:0]                 max_skew
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [2][DEPTH];
    logic [DATA_WIDTH-1:0] din [2];
    logic [CW-1:0]         cnt [2];
    logic [CW-1:0]         wptr [2];
    logic [CW-1:0]         rptr [2];
    logic [1:0]            vld;
    logic [1:0]            rdy;
    logic [1:0]            push;
    logic                  pair_valid;
    logic                  pop;
    logic                  unused;

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] p);
        return (p == CW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign vld    = {in_b.valid, in_a.valid};
    assign din[0] = in_a.data;
    assign din[1] = in_b.data;

    // Ready depends only on registered occupancy, never on downstream ready.
    always_comb begin
        rdy = '0;
        for (int s = 0; s < 2; s++)
            rdy[s] = !reset && (cnt[s] != CW'(DEPTH));
    end

    assign push       = vld & rdy;
    assign pair_valid = (cnt[0] != '0) && (cnt[1] != '0);
    assign pop        = pair_valid && out_a.ready && out_b.ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < DEPTH; i++)
                    mem[s][i] <= '0;
                cnt[s]  <= '0;
                wptr[s] <= '0;
                rptr[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    mem[s][wptr[s][AW-1:0]] <= din[s];
                    wptr[s]                 <= inc(wptr[s]);
                end
                if (pop)
                    rptr[s] <= inc(rptr[s]);
                cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop);
            end
        end
    end

    assign in_a.ready  = rdy[0];
    assign in_b.ready  = rdy[1];
    assign pending_a   = cnt[0];
    assign pending_b   = cnt[1];

    assign out_a.valid = pair_valid;
    assign out_b.valid = pair_valid;
    assign out_a.data  = mem[0][rptr[0][AW-1:0]];
    assign out_b.data  = mem[1][rptr[1][AW-1:0]];
    assign out_a.last  = 1'b0;
    assign out_b.last  = 1'b0;
    assign out_a.dest  = '0;
    assign out_b.dest  = '0;
    assign out_a.user  = 1'b0;
    assign out_b.user  = 1'b0;

    assign unused = ^{in_a.last, in_a.dest, in_a.user, in_b.last, in_b.dest, in_b.user,
                      wptr[0][AW], wptr[1][AW], rptr[0][AW], rptr[1][AW]};

`ifdef ALU_ALIGNER_SKEW_MON_EN
    // Each entry ages since its acceptance; a partner arriving later reads that age.
    logic [15:0]   age [2][DEPTH];
    logic [AW-1:0] pidx [2];
    logic [15:0]   skew;

    function automatic logic [15:0] sat(input logic [15:0] x);
        return (&x) ? x : x + 16'd1;
    endfunction

    always_comb begin
        pidx[0] = rptr[0][AW-1:0] + cnt[1][AW-1:0];
        pidx[1] = rptr[1][AW-1:0] + cnt[0][AW-1:0];
        skew    = (push[1] && cnt[0] > cnt[1]) ? sat(age[0][pidx[0]]) :
                  (push[0] && cnt[1] > cnt[0]) ? sat(age[1][pidx[1]]) : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < DEPTH; i++)
                    age[s][i] <= '0;
            max_skew <= '0;
        end else begin
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < DEPTH; i++)
                    age[s][i] <= (push[s] && wptr[s][AW-1:0] == AW'(i)) ? '0 : sat(age[s][i]);
            max_skew <= (skew > max_skew) ? skew : max_skew;
        end
    end
`endif
endmodule

// File: tb/tb_alu_operand_aligner.sv
// tb_alu_operand_aligner: scoreboard bench; per-side expected queues filled on acceptance, drained on pair pop.
module tb_alu_operand_aligner;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    alu_operand_aligner_if #(.DATA_WIDTH(DW)) in_a ();
    alu_operand_aligner_if #(.DATA_WIDTH(DW)) in_b ();
    alu_operand_aligner_if #(.DATA_WIDTH(DW)) out_a ();
    alu_operand_aligner_if #(.DATA_WIDTH(DW)) out_b ();
    logic [$clog2(DEPTH):0] pending_a, pending_b;
`ifdef ALU_ALIGNER_SKEW_MON_EN
    logic [15:0] max_skew;
`endif

    alu_operand_aligner #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_a     (out_a),
        .out_b     (out_b),
        .pending_a (pending_a),
        .pending_b (pending_b)
`ifdef ALU_ALIGNER_SKEW_MON_EN
        ,
        .max_skew  (max_skew)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic acc_a = 1'b0;
    logic acc_b = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model decides the handshakes of the coming rising edge, half a cycle ahead.
    always @(negedge clock) begin
        if (reset) begin
            qa.delete();
            qb.delete();
            acc_a = 1'b0;
            acc_b = 1'b0;
            check("rst_ready", {in_a.ready, in_b.ready}, '0);
            check("rst_pending", {pending_a, pending_b}, '0);
            check("rst_valid", {out_a.valid, out_b.valid}, '0);
            check("rst_data_a", out_a.data, '0);
            check("rst_data_b", out_b.data, '0);
        end else begin
            logic pv, pop_m;
            pv = qa.size() > 0 && qb.size() > 0;
            check("pending_a", DW'(pending_a), DW'(qa.size()));
            check("pending_b", DW'(pending_b), DW'(qb.size()));
            check("ready_a", DW'(in_a.ready), DW'(qa.size() != DEPTH));
            check("ready_b", DW'(in_b.ready), DW'(qb.size() != DEPTH));
            check("valid", {out_a.valid, out_b.valid}, {pv, pv});
            check("sideband", {out_a.last, out_a.dest, out_a.user, out_b.last, out_b.dest, out_b.user}, '0);
            if (pv) begin
                check("data_a", out_a.data, qa[0]);
                check("data_b", out_b.data, qb[0]);
            end
            pop_m = pv && out_a.ready && out_b.ready;
            acc_a = in_a.valid && qa.size() != DEPTH;
            acc_b = in_b.valid && qb.size() != DEPTH;
            if (pop_m) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (acc_a) qa.push_back(in_a.data);
            if (acc_b) qb.push_back(in_b.data);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_a(input logic [DW-1:0] v);
        int n = 0;
        in_a.valid = 1'b1;
        in_a.data  = v;
        do begin
            @(posedge clock);
            n++;
        end while (!acc_a && n < 100);
        if (n >= 100) check("timeout_a", 0, 1);
        #1;
        in_a.valid = 1'b0;
    endtask

    task automatic push_b(input logic [DW-1:0] v);
        int n = 0;
        in_b.valid = 1'b1;
        in_b.data  = v;
        do begin
            @(posedge clock);
            n++;
        end while (!acc_b && n < 100);
        if (n >= 100) check("timeout_b", 0, 1);
        #1;
        in_b.valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_a.valid = 0; in_a.data = 0; in_a.last = 1; in_a.dest = 4'hf; in_a.user = 1;
        in_b.valid = 0; in_b.data = 0; in_b.last = 1; in_b.dest = 4'h5; in_b.user = 1;
        out_a.ready = 1; out_b.ready = 1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        step();

        // simultaneous pair visible the cycle after acceptance, for one cycle
        in_a.valid = 1; in_a.data = 5;
        in_b.valid = 1; in_b.data = 1;
        step();
        in_a.valid = 0; in_b.valid = 0;
        check("sim_pair", {out_a.data, out_b.data} == {32'd5, 32'd1} && out_a.valid, 1);
        step();
        check("sim_gone", out_a.valid, 0);

        // delayed partner twelve cycles later
        push_a(2);
        repeat (11) @(posedge clock);
        #1;
        check("delay_wait", {pending_a, out_a.valid}, {3'd1, 1'b0});
        push_b(1);
        check("delay_pair", {out_a.data, out_b.data}, {32'd2, 32'd1});
        step();
`ifdef ALU_ALIGNER_SKEW_MON_EN
        check("max_skew_delay", max_skew, 16'd12);
`endif

        // full FIFO A backpressure, then drain in order
        for (int i = 1; i <= 4; i++) push_a(i);
        check("full_ready", in_a.ready, 0);
        fork
            push_a(5);
            begin
                repeat (3) step();
                push_b(10); push_b(20); push_b(30); push_b(40); push_b(50);
            end
        join
        repeat (3) step();

        // output stall holds the pair until both readies are high
        out_a.ready = 0;
        in_a.valid = 1; in_a.data = 7;
        in_b.valid = 1; in_b.data = 8;
        step();
        in_a.valid = 0; in_b.valid = 0;
        repeat (5) step();
        check("stall_held", {pending_a, out_a.data}, {3'd1, 32'd7});
        out_a.ready = 1;
        step();
        check("stall_pop", pending_a, 0);
`ifdef ALU_ALIGNER_SKEW_MON_EN
        check("max_skew_keep", max_skew, 16'd12);
`endif

        // reset mid-operation discards buffered A entries
        push_a(31); push_a(32); push_a(33);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        push_b(9);
        step();
        check("no_stale_pair", out_a.valid, 0);
        push_a(11);
        step();

        // random traffic with random downstream stalls
        for (int c = 0; c < 400; c++) begin
            if (!in_a.valid || acc_a) begin
                in_a.valid = ($urandom_range(0, 2) != 0);
                in_a.data  = $urandom;
            end
            if (!in_b.valid || acc_b) begin
                in_b.valid = ($urandom_range(0, 3) == 0);
                in_b.data  = $urandom;
            end
            out_a.ready = ($urandom_range(0, 3) != 0);
            out_b.ready = ($urandom_range(0, 3) != 0);
            step();
        end
        while (in_a.valid && !acc_a) step();
        in_a.valid = 0;
        while (in_b.valid && !acc_b) step();
        in_b.valid = 0;
        out_a.ready = 1; out_b.ready = 1;
        repeat (10) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
